tdc_hit_encoder: RTL and testbench
==================================

Name: tdc_hit_encoder

Overview:
- Digital back-end stage directly downstream of the TDC delay line.
- Runs a coarse cycle counter from arm to hit and converts the thermometer tap snapshot into a bubble-tolerant fine code.
- Packs each measurement into a 16-bit record, buffers records in a small FIFO, and streams them out as byte pairs over a valid/ready interface toward the chip output pins.

Parameters:
- TAPS, 32, delay-line taps in the thermometer snapshot; FINE_W = clog2(TAPS+1) = 6.
- COARSE_W, 8, coarse counter width; requires COARSE_W + FINE_W <= 14.
- FIFO_DEPTH, 4, record FIFO entries; power of two, >= 2.

Ports:
- clk  in  1  Block clock.
- rst  in  1  Reset, asynchronous, active-high.
- ena  in  1  Block enable; low forces FSM to IDLE.
- arm_i  in  1  1-cycle strobe; starts a measurement.
- hit_i  in  1  1-cycle strobe; taps_i valid, stop event.
- taps_i  in  TAPS  Thermometer snapshot, already synchronised to clk.
- clr_i  in  1  Clears sticky lost_o.
- out_valid  out  1  Byte available.
- out_ready  in  1  Consumer accepts byte.
- out_data  out  8  Record byte; high byte first.
- out_last  out  1  High on the low (second) byte.
- busy_o  out  1  FSM in RUN.
- lost_o  out  1  Sticky: a record was dropped because the FIFO was full.

Behaviour:
- Reset values: all outputs 0; FSM IDLE; coarse = 0; FIFO empty; byte phase = 0.
- The asynchronous reset also applies mid-operation: any in-flight record or partially sent record is discarded.
- FSM has two states, IDLE and RUN.
- IDLE -> RUN on arm_i & ena; coarse is set to 0.
  - hit_i in IDLE is ignored.
  - arm_i and hit_i in the same cycle: arm wins, hit is ignored.
- RUN, each cycle, in priority order:
  1. arm_i: restart, coarse := 0, no record produced.
  2. hit_i: capture {coarse, taps_i} into the encode stage, go to IDLE.
  3. coarse == all-ones: emit an overflow record, go to IDLE.
  4. Otherwise: coarse := coarse + 1.
  - A hit in the same cycle that coarse reaches all-ones counts as a normal hit.
- ena low: FSM goes to IDLE next cycle and coarse clears. The FIFO and output side keep draining.
- Fine code: fine = popcount(taps_i), range 0..TAPS.
  - Using popcount makes the code tolerant to bubbles.
  - Registered in one pipeline stage.
- Record format (16 bits):
  - [15] ovf
  - [14] 0
  - [13:6] coarse, zero-extended if COARSE_W < 8
  - [5:0] fine
  - Overflow record: ovf = 1, coarse = all-ones, fine = 0.
- Latency:
  - hit at cycle N: encode register loaded N+1, FIFO write N+1, out_valid high at N+2 when the FIFO was empty.
  - Overflow record: written in the cycle after the terminal count.
- FIFO full at write time: the record is dropped and lost_o sets.
  - lost_o clears only on clr_i or rst.
  - If clr_i and a drop occur in the same cycle, set wins.
  - A simultaneous read and write when full is a drop; there is no pass-through.
- Output handshake:
  - out_valid = FIFO not empty.
  - Phase 0 presents the high byte; phase 1 presents the low byte with out_last = 1.
  - A byte transfers on out_valid & out_ready.
  - The FIFO entry pops after the phase-1 transfer.
  - out_data and out_last are held stable while out_valid & !out_ready.
  - out_valid never drops without a transfer.
- FIFO pointers carry one extra wrap bit: full = (ptrs equal except MSB), empty = (ptrs equal).

Decomposition:
- tdc_pkg holds:
  - the state enum (IDLE, RUN);
  - record field position constants;
  - the FINE_W helper function;
  - the OVF record constant.
- One sub-module: tdc_sync_fifo (parameterised width/depth, full/empty, wrap-bit pointers).
- Popcount and the FSM stay inline.

Test Plan:
- Arm, hit after 10 cycles with taps = 0x0000_FFFF -> record 0x0290 (coarse 10, fine 16); bytes 0x02 then 0x90, out_last on the second byte.
- Arm, no hit for 256 cycles -> one overflow record 0xBFC0; FSM back in IDLE; busy_o low.
- Hit with bubbled taps 0x0000_F7FF -> fine = 15; same-cycle arm+hit in IDLE -> no record, busy_o high.
- 5 measurements with out_ready = 0 -> 4 records held, lost_o = 1; then stream with random out_ready stalls -> 8 bytes in order, data stable during stalls; clr_i -> lost_o = 0.
- Assert rst during RUN and mid-record (after the high byte) -> all outputs 0 immediately; the next measurement yields a complete fresh record.
- ena dropped during RUN -> IDLE, no record; FIFO contents still drain.

Source files
------------

// File: rtl/tdc_pkg.sv
// TDC hit encoder shared types: FSM states, 16-bit record layout, overflow record, fine-width helper.
package tdc_pkg;

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   localparam int REC_W        = 16;
   localparam int REC_COARSE_W = 8;
   localparam int REC_FINE_W   = 6;

   // Field order fixes bit positions: ovf [15], reserved [14], coarse [13:6], fine [5:0].
   typedef struct packed {
      logic                    ovf;
      logic                    rsvd;
      logic [REC_COARSE_W-1:0] coarse;
      logic [REC_FINE_W-1:0]   fine;
   } rec_t;

   localparam rec_t OVF_REC = '{ovf: 1'b1, rsvd: 1'b0, coarse: '1, fine: '0};

   function automatic int fine_w(input int taps);
      return $clog2(taps + 1);
   endfunction

endpackage

// File: rtl/tdc_sync_fifo.sv
// Sync FIFO, wrap-bit pointers, fall-through read (write visible next cycle).
// Pushes while full and pops while empty are ignored; caller decides what a full push means.
module tdc_sync_fifo #(
   parameter int W     = 16,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         wr_vld,
   input  logic [W-1:0] wr_dat,
   input  logic         rd_rdy,
   output logic [W-1:0] rd_dat,
   output logic         full,
   output logic         empty
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0] mem [DEPTH];
   logic [AW:0]  wr_ptr;
   logic [AW:0]  rd_ptr;
   logic         push;
   logic         pop;

   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign empty = (wr_ptr == rd_ptr);
   assign push  = wr_vld & ~full;
   assign pop   = rd_rdy & ~empty;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr[AW-1:0]] <= wr_dat;
   end

   assign rd_dat = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/tdc_hit_encoder.sv
// Arm-to-hit coarse count + popcount fine code -> 16-bit record -> FIFO -> high/low byte stream.
// Hit to out_valid is 2 cycles; a full FIFO drops the record (sticky lost_o); out_ready stalls hold bytes.
module tdc_hit_encoder
   import tdc_pkg::*;
#(
   parameter int TAPS       = 32,
   parameter int COARSE_W   = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            ena,
   input  logic            arm_i,
   input  logic            hit_i,
   input  logic [TAPS-1:0] taps_i,
   input  logic            clr_i,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [7:0]      out_data,
   output logic            out_last,
   output logic            busy_o,
   output logic            lost_o
);

   localparam int FINE_W = fine_w(TAPS);

   state_t              state;
   state_t              state_nxt;
   logic [COARSE_W-1:0] coarse;
   logic [COARSE_W-1:0] coarse_nxt;
   logic                cap_vld;
   logic                ovf_vld;
   logic [FINE_W-1:0]   popcnt;
   rec_t                hit_rec;
   rec_t                ovf_rec;
   logic                enc_vld;
   rec_t                enc_dat;
   logic [REC_W-1:0]    fifo_rd_dat;
   logic                fifo_full;
   logic                fifo_empty;
   logic                phase;
   logic                xfer;
   logic                drop;

   // Counting ones rather than locating the edge makes bubbles in the thermometer harmless.
   always_comb begin
      popcnt = '0;
      for (int i = 0; i < TAPS; i++) begin
         popcnt = popcnt + FINE_W'(taps_i[i]);
      end
   end

   always_comb begin
      hit_rec        = '0;
      hit_rec.coarse = REC_COARSE_W'(coarse);
      hit_rec.fine   = REC_FINE_W'(popcnt);
      ovf_rec        = OVF_REC;
      ovf_rec.coarse = REC_COARSE_W'({COARSE_W{1'b1}});
   end

   always_comb begin
      state_nxt  = state;
      coarse_nxt = coarse;
      cap_vld    = 1'b0;
      ovf_vld    = 1'b0;
      if (!ena) begin
         state_nxt  = IDLE;
         coarse_nxt = '0;
      end else begin
         case (state)
            IDLE: begin
               if (arm_i) begin
                  state_nxt  = RUN;
                  coarse_nxt = '0;
               end
            end
            RUN: begin
               if (arm_i) begin
                  coarse_nxt = '0;
               end else if (hit_i) begin
                  cap_vld    = 1'b1;
                  state_nxt  = IDLE;
                  coarse_nxt = '0;
               end else if (coarse == '1) begin
                  ovf_vld    = 1'b1;
                  state_nxt  = IDLE;
                  coarse_nxt = '0;
               end else begin
                  coarse_nxt = coarse + COARSE_W'(1);
               end
            end
            default: begin
               state_nxt  = IDLE;
               coarse_nxt = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         coarse  <= '0;
         enc_vld <= 1'b0;
         enc_dat <= '0;
      end else begin
         state   <= state_nxt;
         coarse  <= coarse_nxt;
         enc_vld <= cap_vld | ovf_vld;
         if (cap_vld)      enc_dat <= hit_rec;
         else if (ovf_vld) enc_dat <= ovf_rec;
      end
   end

   // Full is judged before this cycle's pop, so a full FIFO never passes a record through.
   tdc_sync_fifo #(
      .W     (REC_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk    (clk),
      .rst    (rst),
      .wr_vld (enc_vld),
      .wr_dat (enc_dat),
      .rd_rdy (xfer & phase),
      .rd_dat (fifo_rd_dat),
      .full   (fifo_full),
      .empty  (fifo_empty)
   );

   assign drop      = enc_vld & fifo_full;
   assign out_valid = ~fifo_empty;
   assign xfer      = out_valid & out_ready;
   assign out_data  = out_valid ? (phase ? fifo_rd_dat[7:0] : fifo_rd_dat[15:8]) : 8'h00;
   assign out_last  = out_valid & phase;
   assign busy_o    = (state == RUN);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         phase  <= 1'b0;
         lost_o <= 1'b0;
      end else begin
         if (xfer)       phase  <= ~phase;
         if (drop)       lost_o <= 1'b1;
         else if (clr_i) lost_o <= 1'b0;
      end
   end

endmodule

// File: tb/tb_tdc_hit_encoder.sv
// Randomised bench for tdc_hit_encoder: timestamp-based reference model plus literal record checks.
module tb_tdc_hit_encoder;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ena = 1'b1;
   logic        arm_i = 1'b0;
   logic        hit_i = 1'b0;
   logic [31:0] taps_i = '0;
   logic        clr_i = 1'b0;
   logic        out_ready = 1'b0;
   logic        out_valid;
   logic [7:0]  out_data;
   logic        out_last;
   logic        busy_o;
   logic        lost_o;

   always #5 clk = ~clk;

   tdc_hit_encoder dut (
      .clk       (clk),
      .rst       (rst),
      .ena       (ena),
      .arm_i     (arm_i),
      .hit_i     (hit_i),
      .taps_i    (taps_i),
      .clr_i     (clr_i),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_last  (out_last),
      .busy_o    (busy_o),
      .lost_o    (lost_o)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: measurement = arm timestamp; coarse = cycles elapsed since the arm.
   int          cyc = 0;
   bit          m_run = 0;
   int          m_t0 = 0;
   bit          m_pend = 0;
   logic [15:0] m_pend_rec = '0;
   logic [15:0] q[$];
   bit          m_phase = 0;
   bit          m_lost = 0;
   logic [15:0] m_last_rec = '0;
   int          m_coarse;
   bit          m_full;
   bit          m_drop;

   task automatic make_rec(input bit ovf, input int crs, input int fine);
      m_pend_rec = {ovf, 1'b0, 8'(crs), 6'(fine)};
      m_last_rec = m_pend_rec;
      m_pend     = 1;
   endtask

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_run   = 0;
         m_pend  = 0;
         m_phase = 0;
         m_lost  = 0;
         q.delete();
      end else begin
         cyc++;
         m_full = (q.size() == DEPTH);
         if (q.size() != 0 && out_ready) begin
            if (m_phase) void'(q.pop_front());
            m_phase = !m_phase;
         end
         m_drop = 0;
         if (m_pend) begin
            if (m_full) m_drop = 1;
            else        q.push_back(m_pend_rec);
         end
         if (m_drop)     m_lost = 1;
         else if (clr_i) m_lost = 0;
         m_pend   = 0;
         m_coarse = cyc - m_t0 - 1;
         if (!ena) begin
            m_run = 0;
         end else if (arm_i) begin
            m_run = 1;
            m_t0  = cyc;
         end else if (m_run && hit_i) begin
            make_rec(0, m_coarse, $countones(taps_i));
            m_run = 0;
         end else if (m_run && m_coarse == 255) begin
            make_rec(1, 255, 0);
            m_run = 0;
         end
      end
   end

   logic [15:0] head;
   always @(negedge clk) begin
      check("out_valid", out_valid, q.size() != 0);
      check("busy_o", busy_o, m_run);
      check("lost_o", lost_o, m_lost);
      if (q.size() != 0) begin
         head = q[0];
         check("out_data", out_data, m_phase ? head[7:0] : head[15:8]);
         check("out_last", out_last, m_phase);
      end
   end

   // Log of transferred bytes as {last, data}.
   logic [8:0] blog[$];
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) blog.push_back({out_last, out_data});
   end

   function automatic logic [8:0] byte_at(input int i);
      if (i < blog.size()) return blog[i];
      return 9'h1FF;
   endfunction

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic arm();
      arm_i = 1'b1;
      tick();
      arm_i = 1'b0;
   endtask

   task automatic hit(input logic [31:0] t);
      hit_i  = 1'b1;
      taps_i = t;
      tick();
      hit_i  = 1'b0;
   endtask

   task automatic measure(input int gap, input logic [31:0] t);
      arm();
      tick(gap);
      hit(t);
   endtask

   task automatic check_zero_outputs(input string tag);
      check({tag, " out_valid"}, out_valid, 0);
      check({tag, " out_data"}, out_data, 0);
      check({tag, " out_last"}, out_last, 0);
      check({tag, " busy_o"}, busy_o, 0);
      check({tag, " lost_o"}, lost_o, 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int n0;
      rst = 1'b1;
      out_ready = 1'b1;
      tick(3);
      check_zero_outputs("reset");
      rst = 1'b0;
      tick(2);

      // Basic hit: coarse 10, fine 16.
      n0 = blog.size();
      measure(10, 32'h0000_FFFF);
      check("rec1 model", m_last_rec, 16'h0290);
      tick(5);
      check("rec1 nbytes", blog.size() - n0, 2);
      check("rec1 byte0", byte_at(n0), 9'h002);
      check("rec1 byte1", byte_at(n0 + 1), 9'h190);

      // Overflow with no hit.
      n0 = blog.size();
      arm();
      tick(262);
      check("ovf model", m_last_rec, 16'hBFC0);
      check("ovf busy", busy_o, 0);
      check("ovf byte0", byte_at(n0), 9'h0BF);
      check("ovf byte1", byte_at(n0 + 1), 9'h1C0);

      // Bubbled thermometer.
      n0 = blog.size();
      measure(5, 32'h0000_F7FF);
      check("bubble model", m_last_rec, 16'h014F);
      tick(5);
      check("bubble byte0", byte_at(n0), 9'h001);
      check("bubble byte1", byte_at(n0 + 1), 9'h14F);

      // Arm and hit together from IDLE: arm wins.
      n0 = blog.size();
      arm_i = 1'b1;
      hit_i = 1'b1;
      taps_i = 32'h0000_00FF;
      tick();
      arm_i = 1'b0;
      hit_i = 1'b0;
      check("armhit busy", busy_o, 1);
      tick(5);
      check("armhit no record", blog.size() - n0, 0);
      ena = 1'b0;
      tick();
      check("ena busy", busy_o, 0);
      ena = 1'b1;

      // ena drop during RUN while the FIFO drains.
      out_ready = 1'b0;
      measure(3, $urandom);
      measure(7, $urandom);
      tick(3);
      arm();
      tick(4);
      ena = 1'b0;
      out_ready = 1'b1;
      n0 = blog.size();
      tick(8);
      check("ena drain bytes", blog.size() - n0, 4);
      check("ena drop busy", busy_o, 0);
      ena = 1'b1;
      tick(3);
      check("ena no record", blog.size() - n0, 4);

      // Five measurements into a stalled 4-deep FIFO, then a randomly stalled drain.
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         measure($urandom_range(0, 30), $urandom);
         tick(2);
      end
      check("overfill lost", lost_o, 1);
      check("overfill model depth", q.size(), 4);
      n0 = blog.size();
      for (int i = 0; i < 300 && q.size() != 0; i++) begin
         out_ready = 1'($urandom_range(0, 1));
         tick();
      end
      out_ready = 1'b0;
      check("drain complete", q.size(), 0);
      check("drain bytes", blog.size() - n0, 8);
      for (int i = 0; i < 8; i++) check("drain last flag", byte_at(n0 + i) >> 8, i % 2);
      check("lost held", lost_o, 1);
      clr_i = 1'b1;
      tick();
      clr_i = 1'b0;
      check("clr lost", lost_o, 0);

      // Reset during RUN with a record half sent.
      measure(2, $urandom);
      tick(2);
      arm();
      tick(2);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("midrec busy", busy_o, 1);
      check("midrec last", out_last, 1);
      #3;
      rst = 1'b1;
      #1;
      check_zero_outputs("midrun reset");
      tick(2);
      rst = 1'b0;
      out_ready = 1'b1;
      n0 = blog.size();
      measure(3, 32'hFFFF_FFFF);
      tick(5);
      check("post reset nbytes", blog.size() - n0, 2);
      check("post reset byte0", byte_at(n0), 9'h000);
      check("post reset byte1", byte_at(n0 + 1), 9'h1E0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
